// File: rtl/a2d_sched.sv
// Round-robin conversion scheduler and SPI master for the 8-channel 12-bit A2D.
// Result lands one cycle after T2's SS_n rise; go/ch_en are sampled only between pairs, and a started pair always completes.
module a2d_sched #(
    parameter int SCLK_DIV = 32,
    parameter int GAP      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [7:0]  ch_en,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [11:0] res,
    output logic [2:0]  res_ch,
    output logic        res_vld,
    output logic        busy,
    output logic        scan_done
);

    localparam int H      = SCLK_DIV / 2;
    localparam int PERIOD = 2 * (17 * SCLK_DIV + GAP);
    localparam int CW     = $clog2(SCLK_DIV + GAP + 1);
    localparam int PW     = $clog2(PERIOD + 1);

    localparam logic [CW-1:0] H_M1    = CW'(H - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] GAP1_END = CW'(GAP - 1);
    localparam logic [CW-1:0] GAP2_END = CW'(GAP);
    localparam logic [PW-1:0] P_LAST  = PW'(PERIOD - 1);
    localparam logic [PW-1:0] P_MAX   = {PW{1'b1}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PICK  = 3'd1;
    localparam logic [2:0] S_FRONT = 3'd2;
    localparam logic [2:0] S_XFER  = 3'd3;
    localparam logic [2:0] S_BACK  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bitn;
    logic          second;
    logic [2:0]    ch;
    logic [2:0]    last_ch;
    logic [7:0]    en_q;
    logic [14:0]   tx_sh;
    logic [11:0]   rx_sh;
    logic [PW-1:0] pcnt;
    logic          paced;

    logic          go_ok;
    logic          nxt_found;
    logic [2:0]    nxt_ch;
    logic [2:0]    cand;
    logic [15:0]   cmd_nxt;
    logic [15:0]   cmd_cur;

    assign go_ok   = go && (ch_en != 8'd0);
    assign cmd_nxt = {2'b00, nxt_ch, 11'd0};
    assign cmd_cur = {2'b00, ch, 11'd0};

    // Search upward from the last served channel; i = 8 wraps back onto it.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = last_ch;
        cand      = last_ch;
        for (int i = 1; i <= 8; i++) begin
            cand = last_ch + 3'(i);
            if (!nxt_found && ch_en[cand]) begin
                nxt_found = 1'b1;
                nxt_ch    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            res       <= 12'd0;
            res_ch    <= 3'd0;
            res_vld   <= 1'b0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            cnt       <= '0;
            bitn      <= 4'd0;
            second    <= 1'b0;
            ch        <= 3'd0;
            last_ch   <= 3'd7;
            en_q      <= 8'd0;
            tx_sh     <= 15'd0;
            rx_sh     <= 12'd0;
            pcnt      <= '0;
            paced     <= 1'b0;
        end else begin
            res_vld   <= 1'b0;
            scan_done <= 1'b0;
            if (pcnt != P_MAX) pcnt <= pcnt + 1'b1;

            case (state)
                S_IDLE: begin
                    paced <= 1'b0;
                    if (go_ok) state <= S_PICK;
                end

                // Back-to-back pairs are paced to a fixed conversion period.
                S_PICK: begin
                    if (!go_ok) begin
                        state <= S_IDLE;
                    end else if (!paced || pcnt >= P_LAST) begin
                        ch      <= nxt_ch;
                        last_ch <= nxt_ch;
                        en_q    <= ch_en;
                        MOSI    <= cmd_nxt[15];
                        tx_sh   <= cmd_nxt[14:0];
                        SS_n    <= 1'b0;
                        busy    <= 1'b1;
                        second  <= 1'b0;
                        cnt     <= '0;
                        pcnt    <= '0;
                        state   <= S_FRONT;
                    end
                end

                S_FRONT: begin
                    if (cnt == H_M1) begin
                        cnt   <= '0;
                        bitn  <= 4'd0;
                        SCLK  <= 1'b0;
                        state <= S_XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Each period starts on the falling edge; data moves only on the rise.
                S_XFER: begin
                    if (cnt == H_M1) begin
                        SCLK  <= 1'b1;
                        rx_sh <= {rx_sh[10:0], MISO};
                        MOSI  <= tx_sh[14];
                        tx_sh <= {tx_sh[13:0], 1'b0};
                        if (bitn == 4'd15) begin
                            cnt   <= '0;
                            state <= S_BACK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (cnt == DIV_M1) begin
                        cnt  <= '0;
                        bitn <= bitn + 1'b1;
                        SCLK <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_BACK: begin
                    if (cnt == H_M1) begin
                        SS_n  <= 1'b1;
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (cnt == '0 && second) begin
                        res       <= rx_sh;
                        res_ch    <= ch;
                        res_vld   <= 1'b1;
                        scan_done <= ((en_q & (8'hFE << ch)) == 8'd0);
                    end
                    if (!second && cnt == GAP1_END) begin
                        second <= 1'b1;
                        cnt    <= '0;
                        SS_n   <= 1'b0;
                        MOSI   <= cmd_cur[15];
                        tx_sh  <= cmd_cur[14:0];
                        state  <= S_FRONT;
                    end else if (second && cnt == GAP2_END) begin
                        busy   <= 1'b0;
                        paced  <= 1'b1;
                        second <= 1'b0;
                        cnt    <= '0;
                        state  <= go_ok ? S_PICK : S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
